// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and bit-timing helpers.
// The transmitter imports the same package, so both sides agree on timing.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per serial bit, truncated (434 for 50 MHz / 115200).
    function automatic int unsigned calc_bit_time(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_half(input int unsigned bit_time);
        return bit_time / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// First-word fall-through FIFO holding received bytes; the head entry is shown
// combinationally, and a push into a full FIFO is dropped with a one-cycle overrun pulse.
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        do_pop    = pop_req && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
        do_push   = push && (!full || do_pop);
        overrun_d = push && full && !do_pop;
        wr_ptr_d  = wr_ptr_q + AW'(do_push);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        count_d   = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only visible once counted, so reset costs logic for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign valid   = !empty;
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM with glitch rejection and
// break handling, feeding received bytes into an rx_fifo.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    output logic [7:0]               data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     framing_error
);

    localparam int unsigned BIT_TIME = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF     = calc_half(BIT_TIME);
    localparam int unsigned TW       = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TIME - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 framing_error_q, framing_error_d;
    logic                 push;
    logic                 rx;

    assign rx     = sync_q[1];
    assign sync_d = {sync_q[0], serial_in};

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        framing_error_d = 1'b0;
        push            = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rx) state_d = ST_START;
            end
            ST_START: begin
                // Re-check mid start bit so a short low glitch is ignored.
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = rx ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_BREAK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_BREAK: begin
                timer_d = '0;
                if (rx) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q          <= 2'b11;
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            timer_q         <= timer_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            framing_error_q <= framing_error_d;
        end
    end

    rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_q),
        .pop_req   (data_out_ready),
        .head      (data_out),
        .valid     (data_out_valid),
        .count     (count),
        .overrun   (overrun)
    );

    assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default timing: table of back-to-back frames
// plus hand sequences for glitch, framing error/break, full-FIFO push+pop and mid-byte reset.
module tb_uart_rx_fifo;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int DEPTH      = 8;
    localparam int BIT        = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF       = BIT / 2;
    localparam int FRAME      = 10 * BIT;
    // Start bit driven before edge 1: two sync edges, one idle-detect edge, half a bit,
    // then eight data bits plus the stop bit at full bit spacing.
    localparam int PUSH_IDX   = 3 + HALF + 9 * BIT;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic [3:0] count;
    logic       overrun;
    logic       framing_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         exp_count;
        int         exp_ov;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs [9];

    uart_rx_fifo #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .count          (count),
        .overrun        (overrun),
        .framing_error  (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic hold_line(input logic level, input int n, output int fe_n, output int ov_n);
        fe_n = 0;
        ov_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fe_n += int'(framing_error);
            ov_n += int'(overrun);
            serial_in = level;
        end
    endtask

    // Drives one full frame; optional ready pulse aligned with the push edge and optional reset.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit pop_at_push,
                              input int rst_at, output int ev, output int fe_n, output int ov_n);
        int start_count;
        int idx;
        ev   = -1;
        fe_n = 0;
        ov_n = 0;
        start_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) start_count = int'(count);
            if (ev < 0 && i > 0 && (int'(count) != start_count || overrun || framing_error))
                ev = i;
            fe_n += int'(framing_error);
            ov_n += int'(overrun);
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_mid_valid", int'(data_out_valid), 0);
                check("rst_mid_count", int'(count), 0);
                check("rst_mid_data", int'(data_out), 0);
                check("rst_mid_ovr", int'(overrun), 0);
                check("rst_mid_fe", int'(framing_error), 0);
            end
            rst            = (i == rst_at);
            data_out_ready = pop_at_push && (i == PUSH_IDX - 1);
            idx = i / BIT;
            if (idx == 0)      serial_in = 1'b0;
            else if (idx <= 8) serial_in = data[idx-1];
            else               serial_in = stop_bit;
        end
    endtask

    task automatic pop_expect(input string name, input int exp_data);
        @(negedge clk);
        check({name, "_valid"}, int'(data_out_valid), 1);
        check({name, "_data"}, int'(data_out), exp_data);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
    endtask

    initial begin
        int ev, fe_n, ov_n;
        int drain_exp [8];

        vecs[0] = '{8'h00, 1, 0, 8'h00};
        vecs[1] = '{8'h01, 2, 0, 8'h00};
        vecs[2] = '{8'h02, 3, 0, 8'h00};
        vecs[3] = '{8'h03, 4, 0, 8'h00};
        vecs[4] = '{8'h04, 5, 0, 8'h00};
        vecs[5] = '{8'h05, 6, 0, 8'h00};
        vecs[6] = '{8'h06, 7, 0, 8'h00};
        vecs[7] = '{8'h07, 8, 0, 8'h00};
        vecs[8] = '{8'h08, 8, 1, 8'h00};
        drain_exp = '{1, 2, 3, 4, 5, 6, 7, 9};

        rst            = 1'b1;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(data_out_valid), 0);
        check("reset_count", int'(count), 0);
        check("reset_data", int'(data_out), 0);
        check("reset_ovr", int'(overrun), 0);
        check("reset_fe", int'(framing_error), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte, read back with a one-cycle ready pulse.
        send_frame(8'hA5, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
        check("a5_push_cycle", ev, PUSH_IDX);
        check("a5_valid", int'(data_out_valid), 1);
        check("a5_data", int'(data_out), 8'hA5);
        check("a5_count", int'(count), 1);
        check("a5_fe", fe_n, 0);
        @(negedge clk);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        check("a5_pop_valid", int'(data_out_valid), 0);
        check("a5_pop_count", int'(count), 0);
        check("a5_pop_data", int'(data_out), 0);

        // Short low glitch must be rejected; exact timing of the next frame shows the FSM is idle.
        hold_line(1'b0, 100, fe_n, ov_n);
        hold_line(1'b1, 1000, ev, ov_n);
        check("glitch_fe", fe_n + ev, 0);
        check("glitch_ovr", ov_n, 0);
        check("glitch_count", int'(count), 0);
        send_frame(8'hC3, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
        check("post_glitch_cycle", ev, PUSH_IDX);
        pop_expect("post_glitch", 8'hC3);

        // Bad stop bit, then a long break, then a good byte.
        send_frame(8'h3C, 1'b0, 1'b0, -1, ev, fe_n, ov_n);
        check("fe_cycle", ev, PUSH_IDX);
        check("fe_pulses", fe_n, 1);
        check("fe_count", int'(count), 0);
        check("fe_valid", int'(data_out_valid), 0);
        hold_line(1'b0, 2000, fe_n, ov_n);
        check("break_fe", fe_n, 0);
        check("break_count", int'(count), 0);
        hold_line(1'b1, BIT, fe_n, ov_n);
        send_frame(8'h11, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
        check("after_break_count", int'(count), 1);
        check("after_break_fe", fe_n, 0);
        pop_expect("after_break", 8'h11);

        // Ready while empty is ignored.
        @(negedge clk);
        data_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("empty_ready_count", int'(count), 0);
        check("empty_ready_valid", int'(data_out_valid), 0);
        check("empty_ready_data", int'(data_out), 0);
        data_out_ready = 1'b0;

        // Fill to DEPTH and overflow by one.
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].data, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
            check($sformatf("tbl%0d_cycle", i), ev, PUSH_IDX);
            check($sformatf("tbl%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("tbl%0d_ovr", i), ov_n, vecs[i].exp_ov);
            check($sformatf("tbl%0d_head", i), int'(data_out), int'(vecs[i].exp_head));
        end

        // Full FIFO: pop coincides with the push of 0x09.
        send_frame(8'h09, 1'b1, 1'b1, -1, ev, fe_n, ov_n);
        check("full_pp_count", int'(count), 8);
        check("full_pp_ovr", ov_n, 0);
        check("full_pp_head", int'(data_out), 8'h01);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d", i), drain_exp[i]);
        check("drained_valid", int'(data_out_valid), 0);
        check("drained_data", int'(data_out), 0);

        // Reset in the middle of data bit 4 of 0xFF clears a stored byte and the partial frame.
        send_frame(8'h77, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
        check("pre_rst_count", int'(count), 1);
        send_frame(8'hFF, 1'b1, 1'b0, 5 * BIT + HALF, ev, fe_n, ov_n);
        check("post_rst_count", int'(count), 0);
        check("post_rst_fe", fe_n, 0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, ev, fe_n, ov_n);
        check("5a_cycle", ev, PUSH_IDX);
        check("5a_count", int'(count), 1);
        check("5a_data", int'(data_out), 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
